fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write arbiter sharing one sync FIFO write port among NREQ producers.
//   Sits in front of the FIFO and drives its wr/data_in from the granted producer.
//   Grants are burst-locked: the owner keeps the port for up to BURST beats.
//   Per-requester valid/ready handshake; back-pressure comes from the FIFO full flag.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   DW     16  data width; matches the FIFO data_in
//   BURST  4   max beats per grant before forced rotation (>=1)
// PORTS
//   clk        in   1            clock, rising edge
//   rst_n      in   1            reset, asynchronous, active-low
//   req_valid  in   NREQ         bit i: requester i has a word
//   req_data   in   NREQ*DW      requester i data at [i*DW +: DW]
//   req_ready  out  NREQ         bit i: word of requester i accepted this cycle
//   fifo_full  in   1            FIFO full flag
//   fifo_wr    out  1            FIFO write strobe
//   fifo_din   out  DW           FIFO write data
//   grant_vld  out  1            a requester currently owns the port
//   grant_id   out  $clog2(NREQ) current owner index
//   stat_cnt   out  NREQ*16      per-requester accepted-word counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, grant_vld=0, grant_id=0, beat_cnt=0, last_owner=NREQ-1,
//     stat_cnt=0; req_ready=0, fifo_wr=0 (combinational, follow state).
//   FSM states: IDLE and GRANT; owner, beat_cnt and last_owner are registered.
//   IDLE:
//     - If any req_valid, the next cycle is GRANT.
//     - Owner = first valid index searching last_owner+1, +2, ... (mod NREQ).
//     - beat_cnt cleared.
//     - Arbitration latency is one cycle; no transfer happens in IDLE.
//   GRANT, transfer condition: xfer = req_valid[owner] & ~fifo_full.
//     - fifo_wr = xfer; fifo_din = req_data[owner]; req_ready = xfer << owner.
//     - This path is combinational, so the word enters the FIFO in the same cycle.
//   Per beat: on xfer, beat_cnt++.
//   Release: (xfer & beat_cnt==BURST-1) | ~req_valid[owner].
//   On release:
//     - last_owner <= owner.
//     - If another requester is valid, hand off directly (GRANT->GRANT, round-robin
//       from owner+1, no idle cycle) and clear beat_cnt; otherwise go to IDLE.
//     - The releasing owner is re-granted only if it is the sole valid requester.
//   fifo_full: stalls the transfer. Grant and beat_cnt are held; the stall does not
//     count as a beat. If the owner drops valid while full, release applies as usual.
//   Never more than one req_ready bit high; fifo_wr is never high while fifo_full=1.
//   grant_vld=1 exactly in GRANT; grant_id = owner, and holds its last value in IDLE.
//   Requesters must hold data stable while valid and not ready.
//   rst_n asserted mid-burst: return to the reset state immediately.
// CONFIGURATION
//   FIFO_ARB_STATS_EN defined:
//     - stat_cnt[i*16 +: 16] increments on each accepted word of requester i.
//     - Counters saturate at 16'hFFFF and are cleared only by reset.
//   Not defined: stat_cnt tied to 0 and no counter flops are inferred.
// TESTING
//   1. Reset; req_valid=4'b0001, 6 words -> 1 idle cycle, then 4 beats (BURST),
//      release, re-grant to req0 (sole requester) after 1 idle cycle, 2 beats.
//   2. req_valid=4'b1111 held -> grant order 0,1,2,3,0 with 4 beats each and no idle
//      cycle between grants; fifo_din follows the owner's data.
//   3. req0 granted, fifo_full=1 for 3 cycles mid-burst -> fifo_wr=0 and req_ready=0
//      during the stall; grant_id=0 held; burst resumes and completes 4 beats total.
//   4. req2 owner drops valid after 2 beats while req1 is valid -> next grant is req3
//      if valid, else req1; beat_cnt restarts at 0.
//   5. Async rst_n pulse mid-burst -> grant_vld=0 and fifo_wr=0 immediately; after
//      release, req0 has first priority.
//   6. With FIFO_ARB_STATS_EN: 10 words from req1 -> stat_cnt[31:16]=10 and all other
//      counters 0; forced to 16'hFFFF, one more word leaves it at 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and one FIFO write port.
// master: arbiter side. slave: producers plus FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic               grant_vld;
    logic [IW-1:0]      grant_id;
    logic [NREQ*16-1:0] stat_cnt;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_din, grant_vld, grant_id, stat_cnt
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_din, grant_vld, grant_id, stat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NREQ producers.
// Optional per-requester saturating word counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.master     bus
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_GRANT  = 1'b1;
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BURST - 1);
    localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
    localparam logic [IW-1:0]   LAST_INIT = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]      state_r, state_n;
    logic [IW-1:0]   owner_r, owner_n;
    logic [BW-1:0]   beat_r,  beat_n;
    logic [IW-1:0]   last_r,  last_n;

    logic            cur_valid_s;
    logic            xfer_s;
    logic            release_s;
    logic [NREQ-1:0] others_s;
    logic [NREQ-1:0] req_ready_s;
    logic [DW-1:0]   din_s;
    logic [IW:0]     idle_pick_s;
    logic [IW:0]     hand_pick_s;

    // Returns {found, index} of the first set bit searching base+1, base+2, ... base (mod NREQ).
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] vld, input logic [IW-1:0] base);
        logic [IW:0] res;
        int          idx;
        res = {(IW+1){1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!res[IW] && vld[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    // Transfer, release and hand-off candidates for the current owner.
    always_comb begin
        din_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (owner_r == IW'(i)) begin
                din_s = bus.req_data[i*DW +: DW];
            end else begin
                din_s = din_s;
            end
        end
        cur_valid_s = bus.req_valid[owner_r];
        xfer_s      = (state_r == ST_GRANT) && cur_valid_s && !bus.fifo_full;
        release_s   = (state_r == ST_GRANT) && ((xfer_s && (beat_r == BEAT_LAST)) || !cur_valid_s);
        others_s    = bus.req_valid & ~(ONE_HOT0 << owner_r);
        if (xfer_s) begin
            req_ready_s = ONE_HOT0 << owner_r;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
        idle_pick_s = rr_pick(bus.req_valid, last_r);
        hand_pick_s = rr_pick(others_s, owner_r);
    end

    // Next-state logic: IDLE arbitrates for one cycle, GRANT hands off directly when possible.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        beat_n  = beat_r;
        last_n  = last_r;
        case (state_r)
            ST_IDLE: begin
                beat_n = {BW{1'b0}};
                if (idle_pick_s[IW]) begin
                    state_n = ST_GRANT;
                    owner_n = idle_pick_s[IW-1:0];
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    last_n = owner_r;
                    beat_n = {BW{1'b0}};
                    if (hand_pick_s[IW]) begin
                        state_n = ST_GRANT;
                        owner_n = hand_pick_s[IW-1:0];
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (xfer_s) begin
                    beat_n = beat_r + BEAT_ONE;
                end else begin
                    beat_n = beat_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
                beat_n  = {BW{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= {IW{1'b0}};
            beat_r  <= {BW{1'b0}};
            last_r  <= LAST_INIT;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            beat_r  <= beat_n;
            last_r  <= last_n;
        end
    end

    assign bus.fifo_wr   = xfer_s;
    assign bus.fifo_din  = din_s;
    assign bus.req_ready = req_ready_s;
    assign bus.grant_vld = (state_r == ST_GRANT);
    assign bus.grant_id  = owner_r;

`ifdef FIFO_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [15:0] cnt_r;

        // Accepted-word counter, sticks at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= 16'h0000;
            end else if (req_ready_s[gi] && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'h0001;
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign bus.stat_cnt[gi*16 +: 16] = cnt_r;
    end
`else
    assign bus.stat_cnt = {(NREQ*16){1'b0}};
`endif

endmodule
